// File: rtl/platform_collapse_ctl.sv
// Platform collapse sequencer: removes four platform segments in a fixed order.
// Each segment waits, blinks a warning, then drops, all paced by vblnk frame ticks.
module platform_collapse_ctl #(
  parameter int unsigned WAIT_FRAMES  = 180,
  parameter int unsigned WARN_FRAMES  = 60,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       start_game,
  input  logic       pause,
  output logic [3:0] ctl,
  output logic [3:0] warn,
  output logic [2:0] dropped,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, WAIT, WARN, DONE} state_t;

  localparam logic [9:0] WAIT_LAST  = 10'(WAIT_FRAMES - 1);
  localparam logic [9:0] WARN_LAST  = 10'(WARN_FRAMES - 1);
  localparam logic [9:0] BLINK_LAST = 10'(BLINK_FRAMES - 1);

  state_t     state, state_n;
  logic       vblnk_q;
  logic       tick;
  logic       step;
  logic [9:0] frame_cnt, frame_cnt_n;
  logic [9:0] blink_cnt, blink_cnt_n;
  logic       blink, blink_n;
  logic [1:0] idx, idx_n;
  logic [3:0] seg;
  logic [3:0] ctl_n, warn_n;
  logic [2:0] dropped_n;
  logic       done_n;

  assign tick = vblnk & ~vblnk_q;
  assign step = tick & ~pause;
  // segment under threat: idx 0 -> bit 3, idx 3 -> bit 0
  assign seg  = 4'b1000 >> idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vblnk_q   <= 1'b0;
      frame_cnt <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
      idx       <= '0;
      ctl       <= '0;
      warn      <= '0;
      dropped   <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      vblnk_q   <= vblnk;
      frame_cnt <= frame_cnt_n;
      blink_cnt <= blink_cnt_n;
      blink     <= blink_n;
      idx       <= idx_n;
      ctl       <= ctl_n;
      warn      <= warn_n;
      dropped   <= dropped_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    blink_cnt_n = blink_cnt;
    blink_n     = blink;
    idx_n       = idx;
    ctl_n       = ctl;
    warn_n      = warn;
    dropped_n   = dropped;
    done_n      = done;

    if (!start_game) begin
      state_n     = IDLE;
      frame_cnt_n = '0;
      blink_cnt_n = '0;
      blink_n     = 1'b0;
      idx_n       = '0;
      ctl_n       = '0;
      warn_n      = '0;
      dropped_n   = '0;
      done_n      = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n     = WAIT;
          frame_cnt_n = '0;
          blink_cnt_n = '0;
          blink_n     = 1'b0;
          idx_n       = '0;
          ctl_n       = '0;
          warn_n      = '0;
          dropped_n   = '0;
          done_n      = 1'b0;
        end
        WAIT: begin
          if (step) begin
            if (frame_cnt == WAIT_LAST) begin
              state_n     = WARN;
              frame_cnt_n = '0;
              blink_n     = 1'b1;
              blink_cnt_n = '0;
              warn_n      = seg;
            end else begin
              frame_cnt_n = frame_cnt + 10'd1;
            end
          end
        end
        WARN: begin
          if (step) begin
            if (frame_cnt == WARN_LAST) begin
              ctl_n       = ctl | seg;
              dropped_n   = dropped + 3'd1;
              warn_n      = '0;
              frame_cnt_n = '0;
              blink_cnt_n = '0;
              blink_n     = 1'b0;
              if (idx == 2'd3) begin
                state_n = DONE;
                done_n  = 1'b1;
              end else begin
                state_n = WAIT;
                idx_n   = idx + 2'd1;
              end
            end else begin
              frame_cnt_n = frame_cnt + 10'd1;
              if (blink_cnt == BLINK_LAST) begin
                blink_n     = ~blink;
                blink_cnt_n = '0;
              end else begin
                blink_cnt_n = blink_cnt + 10'd1;
              end
              warn_n = blink_n ? seg : 4'b0000;
            end
          end
        end
        DONE: begin
          ctl_n     = '1;
          warn_n    = '0;
          dropped_n = 3'd4;
          done_n    = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_platform_collapse_ctl.sv
// Bench for platform_collapse_ctl: two parameter sets driven by shared stimulus,
// checked every cycle against a tick-count model plus directed scenario checks.
module tb_platform_collapse_ctl;

  logic       clk = 1'b0;
  logic       rst, vblnk, start_game, pause;
  logic [3:0] ctl_a, warn_a, ctl_b, warn_b;
  logic [2:0] dropped_a, dropped_b;
  logic       done_a, done_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  platform_collapse_ctl #(.WAIT_FRAMES(4), .WARN_FRAMES(2), .BLINK_FRAMES(1)) dut_a (
    .clk(clk), .rst(rst), .vblnk(vblnk), .start_game(start_game), .pause(pause),
    .ctl(ctl_a), .warn(warn_a), .dropped(dropped_a), .done(done_a)
  );

  platform_collapse_ctl #(.WAIT_FRAMES(3), .WARN_FRAMES(7), .BLINK_FRAMES(2)) dut_b (
    .clk(clk), .rst(rst), .vblnk(vblnk), .start_game(start_game), .pause(pause),
    .ctl(ctl_b), .warn(warn_b), .dropped(dropped_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: the game is a count of effective frame ticks since start; every
  // output follows arithmetically from that count and the three frame lengths.
  bit m_run = 1'b0;
  int m_t   = 0;
  bit m_vq  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_run <= 1'b0;
      m_t   <= 0;
      m_vq  <= 1'b0;
    end else begin
      if (!start_game) begin
        m_run <= 1'b0;
        m_t   <= 0;
      end else if (!m_run) begin
        m_run <= 1'b1;
        m_t   <= 0;
      end else if (vblnk && !m_vq && !pause) begin
        m_t <= m_t + 1;
      end
      m_vq <= vblnk;
    end
  end

  function automatic logic [11:0] expect_out(bit run, int t, int w, int n, int b);
    int d, r, k;
    logic [3:0] c, wm;
    if (!run) return '0;
    d = t / (w + n);
    if (d > 4) d = 4;
    c  = ~(4'hF >> d);
    wm = 4'b0000;
    if (d < 4) begin
      r = t % (w + n);
      if (r >= w) begin
        k = r - w;
        if (((k / b) % 2) == 0) wm = 4'b1000 >> d;
      end
    end
    return {c, wm, 3'(d), (d == 4)};
  endfunction

  always @(negedge clk) begin
    logic [11:0] ea, eb;
    ea = expect_out(m_run, m_t, 4, 2, 1);
    eb = expect_out(m_run, m_t, 3, 7, 2);
    check("a_ctl",     32'(ctl_a),     32'(ea[11:8]));
    check("a_warn",    32'(warn_a),    32'(ea[7:4]));
    check("a_dropped", 32'(dropped_a), 32'(ea[3:1]));
    check("a_done",    32'(done_a),    32'(ea[0]));
    check("b_ctl",     32'(ctl_b),     32'(eb[11:8]));
    check("b_warn",    32'(warn_b),    32'(eb[7:4]));
    check("b_dropped", 32'(dropped_b), 32'(eb[3:1]));
    check("b_done",    32'(done_b),    32'(eb[0]));
  end

  task automatic do_tick();
    @(negedge clk) vblnk = 1'b1;
    @(negedge clk) vblnk = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  task automatic restart();
    @(negedge clk) start_game = 1'b0;
    @(negedge clk) start_game = 1'b1;
  endtask

  initial begin
    rst = 1'b1; vblnk = 1'b0; start_game = 1'b0; pause = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctl",  32'(ctl_a),     32'h0);
    check("rst_warn", 32'(warn_a),    32'h0);
    check("rst_drop", 32'(dropped_a), 32'h0);
    check("rst_done", 32'(done_a),    32'h0);
    rst = 1'b0; start_game = 1'b1;

    // first segment: warn on 4th tick, blink off on 5th, drop on 6th
    ticks(4); check("seq_warn4", 32'(warn_a), 32'h8);
    ticks(1); check("seq_warn5", 32'(warn_a), 32'h0);
    ticks(1); check("seq_ctl6",  32'(ctl_a), 32'h8);
              check("seq_drop6", 32'(dropped_a), 32'h1);
    ticks(18); check("all_ctl",  32'(ctl_a), 32'hF);
               check("all_drop", 32'(dropped_a), 32'h4);
               check("all_done", 32'(done_a), 32'h1);
    ticks(3);  check("hold_ctl", 32'(ctl_a), 32'hF);
               check("hold_done", 32'(done_a), 32'h1);

    // stop coincident with the dropping tick of segment 2
    restart();
    ticks(11); check("pre_stop_ctl", 32'(ctl_a), 32'h8);
    @(negedge clk) begin vblnk = 1'b1; start_game = 1'b0; end
    @(negedge clk);
    check("stop_ctl",  32'(ctl_a), 32'h0);
    check("stop_drop", 32'(dropped_a), 32'h0);
    check("stop_warn", 32'(warn_a), 32'h0);
    vblnk = 1'b0; start_game = 1'b1;

    // pause masks ticks in WAIT
    ticks(2);
    pause = 1'b1;
    ticks(10); check("pause_warn", 32'(warn_a), 32'h0);
               check("pause_ctl",  32'(ctl_a), 32'h0);
    pause = 1'b0;
    ticks(1); check("unpause1", 32'(warn_a), 32'h0);
    ticks(1); check("unpause2", 32'(warn_a), 32'h8);

    // long vblnk high is a single tick
    restart();
    @(negedge clk) vblnk = 1'b1;
    repeat (100) @(negedge clk);
    vblnk = 1'b0;
    check("long_hi", 32'(warn_a), 32'h0);
    ticks(2); check("long_hi2", 32'(warn_a), 32'h0);
    ticks(1); check("long_hi3", 32'(warn_a), 32'h8);

    // reset during segment-2 warning restarts from ctl[3]
    restart();
    ticks(10); check("seg2_warn", 32'(warn_a), 32'h4);
               check("seg2_ctl",  32'(ctl_a), 32'h8);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("mid_rst_ctl",  32'(ctl_a), 32'h0);
    check("mid_rst_warn", 32'(warn_a), 32'h0);
    check("mid_rst_drop", 32'(dropped_a), 32'h0);
    ticks(5); check("rst_re5", 32'(ctl_a), 32'h0);
    ticks(1); check("rst_re6", 32'(ctl_a), 32'h8);
              check("rst_re6d", 32'(dropped_a), 32'h1);

    // randomized phase, checked by the per-cycle model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 999) == 0);
      start_game = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      if ($urandom_range(0, 2) == 0) vblnk = ~vblnk;
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
